aes_decrypt_sequencer: RTL and testbench

Iterative AES-128 decryption controller that time-shares one registered round datapath (init / middle / final modes) across all 11 decryption stages.
- Accepts one ciphertext block over a valid/ready handshake.
- Drives the round datapath with mode, data and round-key index, in reverse key order 10..0.
- Returns the plaintext over a valid/ready handshake with backpressure.
- Sits between the block I/O wrapper, the round-key store and the round datapath.

---
 rtl/aes_pkg.sv | 18 +
 rtl/aes_decrypt_sequencer.sv | 126 ++++++++++++
 tb/tb_aes_decrypt_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES-128 decryption sequencer.
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_BLK_W = 128;

  localparam logic [1:0] RND_INIT  = 2'd0;
  localparam logic [1:0] RND_MID   = 2'd1;
  localparam logic [1:0] RND_FINAL = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE_INIT,
    ST_WAIT,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/aes_decrypt_sequencer.sv
// Time-shares one round datapath across all AES-128 decryption stages, keys NR..0.
//
// state         | meaning
// ST_IDLE       | waiting for a ciphertext block (needs keys_valid)
// ST_ISSUE_INIT | issue the AddRoundKey stage with key NR
// ST_WAIT       | on each rnd_done issue the next stage, or capture the result
// ST_DONE       | hold plaintext until out_ready
module aes_decrypt_sequencer
  import aes_pkg::*;
#(
  parameter int NR     = AES_NR,
  parameter int KIDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  input  logic                 keys_valid,
  output logic [KIDX_W-1:0]    key_idx,
  input  logic [AES_BLK_W-1:0] key_data,
  output logic                 rnd_start,
  output logic [1:0]           rnd_mode,
  output logic [AES_BLK_W-1:0] rnd_din,
  output logic [AES_BLK_W-1:0] rnd_key,
  input  logic                 rnd_done,
  input  logic [AES_BLK_W-1:0] rnd_dout,
  input  logic                 flush,
  output logic                 busy
);

  seq_state_t           state, state_nxt;
  logic [KIDX_W-1:0]    cnt, cnt_nxt;
  logic                 final_pending, final_pending_nxt;
  logic [AES_BLK_W-1:0] blk;

  // rst_n term keeps in_ready low while reset is asserted
  assign in_ready = rst_n && (state == ST_IDLE) && keys_valid && !flush;
  assign busy     = (state != ST_IDLE);
  assign rnd_key  = key_data;

  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    final_pending_nxt = final_pending;
    rnd_start         = 1'b0;
    rnd_mode          = RND_INIT;
    key_idx           = '0;
    rnd_din           = blk;
    case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) state_nxt = ST_ISSUE_INIT;
      end
      ST_ISSUE_INIT: begin
        rnd_start = 1'b1;
        key_idx   = KIDX_W'(NR);
        cnt_nxt   = KIDX_W'(NR - 1);
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (rnd_done) begin
          if (final_pending) begin
            final_pending_nxt = 1'b0;
            state_nxt         = ST_DONE;
          end else if (cnt != '0) begin
            rnd_start = 1'b1;
            rnd_mode  = RND_MID;
            key_idx   = cnt;
            rnd_din   = rnd_dout;
            cnt_nxt   = cnt - KIDX_W'(1);
          end else begin
            rnd_start         = 1'b1;
            rnd_mode          = RND_FINAL;
            rnd_din           = rnd_dout;
            final_pending_nxt = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // a stage issued during flush would only produce a result we discard
    if (flush) begin
      state_nxt         = ST_IDLE;
      cnt_nxt           = '0;
      final_pending_nxt = 1'b0;
      rnd_start         = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      final_pending <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      final_pending <= final_pending_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (state == ST_IDLE && in_valid && in_ready) blk <= in_data;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (state == ST_WAIT && rnd_done && final_pending) begin
        out_valid <= 1'b1;
        out_data  <= rnd_dout;
      end else if (state == ST_DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_decrypt_sequencer.sv
// Directed bench for aes_decrypt_sequencer with a behavioural inverse-round datapath.
module tb_aes_decrypt_sequencer;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [127:0] in_data;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic         keys_valid;
  logic [3:0]   key_idx;
  logic [127:0] key_data;
  logic         rnd_start;
  logic [1:0]   rnd_mode;
  logic [127:0] rnd_din, rnd_key;
  logic         rnd_done;
  logic [127:0] rnd_dout;
  logic         flush;
  logic         busy;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]   sbox     [256];
  logic [7:0]   inv_sbox [256];
  logic [127:0] rk       [11];

  logic [6:0]   start_q [$];
  int           n_start = 0;

  int           dp_lat = 1;
  int           dp_cnt;
  logic [127:0] dp_res;

  always #5 clk = ~clk;

  aes_decrypt_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .keys_valid (keys_valid),
    .key_idx    (key_idx),
    .key_data   (key_data),
    .rnd_start  (rnd_start),
    .rnd_mode   (rnd_mode),
    .rnd_din    (rnd_din),
    .rnd_key    (rnd_key),
    .rnd_done   (rnd_done),
    .rnd_dout   (rnd_dout),
    .flush      (flush),
    .busy       (busy)
  );

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]     = s;
      inv_sbox[s] = 8'(x);
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Standard inverse cipher round; byte i of the block is row i%4, column i/4
  function automatic logic [127:0] inv_round(input logic [127:0] din, input logic [127:0] key,
                                             input logic [1:0] mode);
    logic [127:0] t, u;
    logic [7:0]   a0, a1, a2, a3;
    if (mode == 2'd0) return din ^ key;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[127-8*(r+4*c) -: 8] = inv_sbox[gb(din, r + 4*((c - r + 4) % 4))];
    t ^= key;
    if (mode == 2'd2) return t;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(t, 4*c); a1 = gb(t, 4*c+1); a2 = gb(t, 4*c+2); a3 = gb(t, 4*c+3);
      u[127-8*(4*c)   -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
      u[127-8*(4*c+1) -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
      u[127-8*(4*c+2) -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
      u[127-8*(4*c+3) -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
    end
    return u;
  endfunction

  assign key_data = (key_idx <= 4'd10) ? rk[key_idx] : 128'h0;
  assign rnd_done = (dp_cnt == 1);
  assign rnd_dout = dp_res;

  // Round datapath with dp_lat cycles from issue to result
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_cnt <= 0;
      dp_res <= '0;
    end else if (rnd_start) begin
      dp_res <= inv_round(rnd_din, rnd_key, rnd_mode);
      dp_cnt <= dp_lat;
    end else if (dp_cnt > 0) begin
      dp_cnt <= dp_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (rst_n && rnd_start) begin
      start_q.push_back({key_idx, rnd_mode, rnd_done});
      n_start++;
    end
  end

  task automatic reset_checks(input string tag);
    chk_eq({tag, ".in_ready"},  in_ready,  0);
    chk_eq({tag, ".out_valid"}, out_valid, 0);
    chk_eq({tag, ".out_data"},  out_data,  0);
    chk_eq({tag, ".rnd_start"}, rnd_start, 0);
    chk_eq({tag, ".rnd_mode"},  rnd_mode,  0);
    chk_eq({tag, ".key_idx"},   key_idx,   0);
    chk_eq({tag, ".busy"},      busy,      0);
  endtask

  // Called just after a negedge; returns just after a negedge with the block drained
  task automatic do_block(input logic [127:0] ct, input logic [127:0] pt, input int lat,
                          input int stall, input bit drop_kv, input string tag);
    int          d;
    bit          seen_rdy, unstable;
    logic [43:0] kseq;
    logic [21:0] mseq, mexp;
    logic [10:0] dseq;
    logic [6:0]  e;
    dp_lat    = lat;
    in_data   = ct;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1;
    d = 0;
    while (!in_ready && d < 50) begin @(negedge clk); #1; d++; end
    chk_eq({tag, ".accept"}, in_ready, 1);
    start_q.delete();
    @(negedge clk);
    in_valid = 1'b0;
    if (drop_kv) keys_valid = 1'b0;
    d = 1;
    seen_rdy = 0;
    while (!out_valid && d < 200) begin
      if (in_ready) seen_rdy = 1;
      @(negedge clk);
      d++;
    end
    chk_eq({tag, ".latency"}, 128'(d), 128'(11*lat + 2));
    chk_eq({tag, ".plaintext"}, out_data, pt);
    unstable = 0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!out_valid || out_data !== pt) unstable = 1;
      if (in_ready) seen_rdy = 1;
    end
    chk_eq({tag, ".hold_stable"}, unstable, 0);
    keys_valid = 1'b1;
    out_ready  = 1'b1;
    #1;
    chk_eq({tag, ".ready_in_done"}, in_ready, 0);
    chk_eq({tag, ".ready_while_busy"}, seen_rdy, 0);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk_eq({tag, ".valid_dropped"}, out_valid, 0);
    chk_eq({tag, ".ready_after"}, in_ready, 1);
    chk_eq({tag, ".n_starts"}, 128'(start_q.size()), 11);
    kseq = '0; mseq = '0; dseq = '0; mexp = '0;
    for (int i = 0; i < 11; i++) begin
      e    = (i < start_q.size()) ? start_q[i] : 7'h7f;
      kseq = {kseq[39:0], e[6:3]};
      mseq = {mseq[19:0], e[2:1]};
      dseq = {dseq[9:0], e[0]};
      mexp = {mexp[19:0], (i == 0) ? 2'd0 : (i == 10) ? 2'd2 : 2'd1};
    end
    chk_eq({tag, ".key_seq"}, kseq, 44'hA9876543210);
    chk_eq({tag, ".mode_seq"}, mseq, mexp);
    chk_eq({tag, ".start_on_done"}, dseq, 11'b011_1111_1111);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  d, snap;
    bit  seen;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    keys_valid = 1'b1;
    flush      = 1'b0;
    build_tables();
    expand_key(KEY);
    repeat (3) @(negedge clk);
    #1;
    reset_checks("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_block(CT, PT, 1, 0, 0, "basic");
    @(negedge clk);
    do_block(CT, PT, 1, 20, 0, "stall");
    @(negedge clk);

    keys_valid = 1'b0;
    in_valid   = 1'b1;
    in_data    = CT;
    snap       = n_start;
    seen       = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (in_ready) seen = 1;
    end
    chk_eq("nokeys.in_ready", seen, 0);
    chk_eq("nokeys.no_start", 128'(n_start), 128'(snap));
    keys_valid = 1'b1;
    do_block(CT, PT, 1, 0, 0, "keys_up");
    @(negedge clk);

    dp_lat   = 3;
    in_data  = CT;
    in_valid = 1'b1;
    start_q.delete();
    @(negedge clk);
    in_valid = 1'b0;
    d = 0;
    while (start_q.size() < 5 && d < 100) begin @(negedge clk); d++; end
    chk_eq("flush.five_starts", 128'(start_q.size()), 5);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk_eq("flush.idle", busy, 0);
    chk_eq("flush.out_valid", out_valid, 0);
    snap = n_start;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1;
    end
    chk_eq("flush.late_done_ignored", seen, 0);
    chk_eq("flush.no_more_starts", 128'(n_start), 128'(snap));
    do_block(CT, PT, 1, 0, 0, "after_flush");
    @(negedge clk);

    dp_lat   = 1;
    in_data  = CT;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    reset_checks("rst_mid");
    repeat (3) @(negedge clk);
    #1;
    reset_checks("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    do_block(CT, PT, 1, 0, 0, "after_rst");
    @(negedge clk);

    do_block(CT, PT, 3, 2, 1, "lat3");
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
